// File: rtl/ahb_gpio_param_if.sv
// AHB-Lite slave-side bus bundle for the GPIO block (32-bit address and data).
interface ahb_gpio_param_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/ahb_gpio_param.sv
// Zero-wait-state AHB-Lite GPIO: output register with direction control, SET/CLR
// aliases, synchronised inputs and sticky edge interrupts with W1C status.
module ahb_gpio_param #(
    parameter int unsigned GPIO_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_gpio_param_if.slave       bus,
    input  logic [GPIO_WIDTH-1:0] GPIOIN,
    output logic [GPIO_WIDTH-1:0] GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIOEN,
    output logic                  GPIOINT
);

    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] ADDR_DATA  = 8'h00;
    localparam logic [AW-1:0] ADDR_DIR   = 8'h04;
    localparam logic [AW-1:0] ADDR_SET   = 8'h08;
    localparam logic [AW-1:0] ADDR_CLR   = 8'h0C;
    localparam logic [AW-1:0] ADDR_IE    = 8'h10;
    localparam logic [AW-1:0] ADDR_IPOL  = 8'h14;
    localparam logic [AW-1:0] ADDR_ISTAT = 8'h18;

    typedef logic [GPIO_WIDTH-1:0] gpio_t;

    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic          valid_q, valid_d;
    gpio_t         dataout_q, dataout_d;
    gpio_t         dir_q, dir_d;
    gpio_t         ie_q, ie_d;
    gpio_t         ipol_q, ipol_d;
    gpio_t         istat_q, istat_d;
    gpio_t         prev_q, prev_d;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q, sync_d;

    logic  accept;
    logic  wr_en;
    logic  rd_en;
    gpio_t wdata;
    gpio_t w1c;
    gpio_t sync_in;
    gpio_t edge_det;
    gpio_t rd_val;

    // Address phase capture; held while another slave stretches the bus.
    always_comb begin
        accept  = bus.HREADY & bus.HSEL & bus.HTRANS[1];
        addr_d  = addr_q;
        write_d = write_q;
        valid_d = valid_q;
        if (bus.HREADY) begin
            valid_d = accept;
            if (accept) begin
                addr_d  = bus.HADDR[AW-1:0];
                write_d = bus.HWRITE;
            end
        end
    end

    assign wr_en   = valid_q & write_q & bus.HREADY;
    assign rd_en   = valid_q & ~write_q;
    assign wdata   = bus.HWDATA[GPIO_WIDTH-1:0];
    assign sync_in = sync_q[SYNC_STAGES-1];

    // Register writes and input edge detection; a coincident edge beats W1C.
    always_comb begin
        dataout_d = dataout_q;
        dir_d     = dir_q;
        ie_d      = ie_q;
        ipol_d    = ipol_q;
        w1c       = '0;
        if (wr_en) begin
            case (addr_q)
                ADDR_DATA:  dataout_d = (dataout_q & ~dir_q) | (wdata & dir_q);
                ADDR_DIR:   dir_d     = wdata;
                ADDR_SET:   dataout_d = dataout_q | wdata;
                ADDR_CLR:   dataout_d = dataout_q & ~wdata;
                ADDR_IE:    ie_d      = wdata;
                ADDR_IPOL:  ipol_d    = wdata;
                ADDR_ISTAT: w1c       = wdata;
                default:    ;
            endcase
        end
        sync_d   = {sync_q[SYNC_STAGES-2:0], GPIOIN};
        prev_d   = sync_in;
        edge_det = ~dir_q & ((~ipol_q & sync_in & ~prev_q) | (ipol_q & ~sync_in & prev_q));
        istat_d  = (istat_q & ~w1c) | edge_det;
    end

    // Read mux reflects current state, so a read right after a write sees it.
    always_comb begin
        rd_val = '0;
        if (rd_en) begin
            case (addr_q)
                ADDR_DATA:  rd_val = (dataout_q & dir_q) | (sync_in & ~dir_q);
                ADDR_DIR:   rd_val = dir_q;
                ADDR_IE:    rd_val = ie_q;
                ADDR_IPOL:  rd_val = ipol_q;
                ADDR_ISTAT: rd_val = istat_q;
                default:    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            valid_q   <= 1'b0;
            dataout_q <= '0;
            dir_q     <= '0;
            ie_q      <= '0;
            ipol_q    <= '0;
            istat_q   <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
        end else begin
            addr_q    <= addr_d;
            write_q   <= write_d;
            valid_q   <= valid_d;
            dataout_q <= dataout_d;
            dir_q     <= dir_d;
            ie_q      <= ie_d;
            ipol_q    <= ipol_d;
            istat_q   <= istat_d;
            prev_q    <= prev_d;
            sync_q    <= sync_d;
        end
    end

    assign bus.HRDATA    = 32'(rd_val);
    assign bus.HREADYOUT = 1'b1;
    assign GPIOOUT       = dataout_q;
    assign GPIOEN        = dir_q;
    assign GPIOINT       = |(istat_q & ie_q);

    logic unused_bus;
    assign unused_bus = ^{bus.HADDR[31:AW], bus.HTRANS[0], bus.HWDATA};

endmodule

// File: tb/tb_ahb_gpio_param.sv
// Scoreboard bench for ahb_gpio_param: 16-bit default instance plus a 32-bit instance.
module tb_ahb_gpio_param;

    logic        clk;
    logic        rst_n;
    logic        rst32_n;
    logic [15:0] gpio16;
    logic [15:0] out16, en16;
    logic        int16;
    logic [31:0] gpio32;
    logic [31:0] out32, en32;
    logic        int32;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    ahb_gpio_param_if b16();
    ahb_gpio_param_if b32();

    ahb_gpio_param dut16 (
        .HCLK(clk), .HRESETn(rst_n), .bus(b16),
        .GPIOIN(gpio16), .GPIOOUT(out16), .GPIOEN(en16), .GPIOINT(int16)
    );

    ahb_gpio_param #(.GPIO_WIDTH(32), .SYNC_STAGES(2)) dut32 (
        .HCLK(clk), .HRESETn(rst32_n), .bus(b32),
        .GPIOIN(gpio32), .GPIOOUT(out32), .GPIOEN(en32), .GPIOINT(int32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        b16.HSEL = 1'b0; b16.HTRANS = 2'b00; b16.HWRITE = 1'b0; b16.HREADY = 1'b1;
    endtask

    task automatic addr_ph(input logic [7:0] a, input logic wr, input logic sel,
                           input logic [1:0] tr, input logic rdy);
        b16.HSEL = sel; b16.HTRANS = tr; b16.HWRITE = wr;
        b16.HADDR = {24'h400000, a}; b16.HREADY = rdy;
    endtask

    task automatic bus_xfer(input logic [7:0] a, input logic [31:0] d, input logic sel,
                            input logic [1:0] tr, input logic rdy);
        @(posedge clk); #1; addr_ph(a, 1'b1, sel, tr, rdy);
        @(posedge clk); #1; idle16(); b16.HWDATA = d;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus_xfer(a, d, 1'b1, 2'b10, 1'b1);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] got);
        @(posedge clk); #1; addr_ph(a, 1'b0, 1'b1, 2'b10, 1'b1);
        @(posedge clk); #1; idle16();
        @(negedge clk); got = b16.HRDATA;
    endtask

    task automatic w32(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        b32.HSEL = 1'b1; b32.HTRANS = 2'b10; b32.HWRITE = 1'b1; b32.HADDR = {24'h0, a};
        @(posedge clk); #1;
        b32.HSEL = 1'b0; b32.HTRANS = 2'b00; b32.HWRITE = 1'b0; b32.HWDATA = d;
    endtask

    task automatic r32(input logic [7:0] a, output logic [31:0] got);
        @(posedge clk); #1;
        b32.HSEL = 1'b1; b32.HTRANS = 2'b10; b32.HWRITE = 1'b0; b32.HADDR = {24'h0, a};
        @(posedge clk); #1;
        b32.HSEL = 1'b0; b32.HTRANS = 2'b00;
        @(negedge clk); got = b32.HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        gpio16 = 16'h0008;
        cyc(3);
        tests_run++;
        if ({out16, en16, int16, b16.HREADYOUT} !== {16'h0, 16'h0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got out=%h en=%h int=%b rdy=%b expected 0/0/0/1",
                     out16, en16, int16, b16.HREADYOUT);
        end
        rst_n = 1'b1; rst32_n = 1'b1;
        exp_q.push_back(32'h0);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL reset_istat_early: got %h expected %h", got, e); end
        exp_q.push_back(32'h0000_0008);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL reset_istat_edge: got %h expected %h", got, e); end
        tests_run++;
        if (int16 !== 1'b0) begin tests_failed++; $display("FAIL reset_no_int: got %b expected 0", int16); end
        exp_q.push_back(32'h0000_0008);
        bus_read(8'h00, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL reset_data_in: got %h expected %h", got, e); end
        bus_write(8'h18, 32'h0000_0008);
    endtask

    task automatic test_data_dir();
        logic [31:0] got, e;
        gpio16 = 16'hAB00;
        bus_write(8'h04, 32'hFFFF_00FF);
        bus_write(8'h00, 32'h0000_FFFF);
        cyc(1);
        tests_run++;
        if ({out16, en16} !== {16'h00FF, 16'h00FF}) begin
            tests_failed++;
            $display("FAIL data_dir_out: got out=%h en=%h expected 00ff/00ff", out16, en16);
        end
        exp_q.push_back(32'h0000_00FF);
        bus_read(8'h04, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL dir_readback: got %h expected %h", got, e); end
        exp_q.push_back(32'h0000_ABFF);
        bus_read(8'h00, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL data_mixed_read: got %h expected %h", got, e); end
    endtask

    task automatic test_set_clr();
        logic [31:0] got, e;
        bus_write(8'h00, 32'h0000_00F0);
        bus_write(8'h08, 32'h0000_000F);
        bus_write(8'h0C, 32'h0000_0030);
        cyc(1);
        tests_run++;
        if (out16 !== 16'h00CF) begin tests_failed++; $display("FAIL set_clr_out: got %h expected 00cf", out16); end
        exp_q.push_back(32'h0);
        bus_read(8'h08, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL set_reads_zero: got %h expected %h", got, e); end
        exp_q.push_back(32'h0);
        bus_read(8'h0C, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL clr_reads_zero: got %h expected %h", got, e); end
        bus_write(8'h08, 32'h0000_0100);
        cyc(1);
        tests_run++;
        if ({out16, en16} !== {16'h01CF, 16'h00FF}) begin
            tests_failed++;
            $display("FAIL set_ignores_dir: got out=%h en=%h expected 01cf/00ff", out16, en16);
        end
        bus_write(8'h0C, 32'h0000_0100);
        cyc(1);
        tests_run++;
        if (out16 !== 16'h00CF) begin tests_failed++; $display("FAIL clr_ignores_dir: got %h expected 00cf", out16); end
        exp_q.push_back(32'h0000_ABCF);
        bus_read(8'h00, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL data_after_setclr: got %h expected %h", got, e); end
    endtask

    task automatic test_ignored();
        logic [31:0] got, e;
        bus_xfer(8'h00, 32'h0, 1'b0, 2'b10, 1'b1);
        bus_xfer(8'h00, 32'h0, 1'b1, 2'b01, 1'b1);
        bus_xfer(8'h00, 32'h0, 1'b1, 2'b00, 1'b1);
        bus_xfer(8'h00, 32'h0, 1'b1, 2'b10, 1'b0);
        bus_xfer(8'h04, 32'h0, 1'b1, 2'b10, 1'b0);
        bus_write(8'h1C, 32'hFFFF_FFFF);
        cyc(1);
        tests_run++;
        if ({out16, en16} !== {16'h00CF, 16'h00FF}) begin
            tests_failed++;
            $display("FAIL ignored_xfers: got out=%h en=%h expected 00cf/00ff", out16, en16);
        end
        exp_q.push_back(32'h0);
        bus_read(8'h1C, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL unmapped_1c: got %h expected %h", got, e); end
        exp_q.push_back(32'h0);
        bus_read(8'h20, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL unmapped_20: got %h expected %h", got, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e;
        bus_write(8'h10, 32'h0000_5A5A);
        exp_q.push_back(32'h0000_5A5A);
        bus_read(8'h10, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL ie_raw: got %h expected %h", got, e); end
        tests_run++;
        if (int16 !== 1'b1) begin tests_failed++; $display("FAIL int_level_on: got %b expected 1", int16); end
        exp_q.push_back(32'h0000_AB00);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL istat_sticky: got %h expected %h", got, e); end
        bus_write(8'h14, 32'h0000_0F0F);
        exp_q.push_back(32'h0000_0F0F);
        bus_read(8'h14, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL ipol_raw: got %h expected %h", got, e); end
        bus_write(8'h14, 32'h0);
        bus_write(8'h10, 32'h0);
        cyc(1);
        tests_run++;
        if (int16 !== 1'b0) begin tests_failed++; $display("FAIL int_masked: got %b expected 0", int16); end
    endtask

    task automatic test_sync();
        logic [31:0] got, e;
        bus_write(8'h04, 32'h0);
        gpio16 = 16'h0000;
        cyc(4);
        gpio16 = 16'h1234;
        addr_ph(8'h00, 1'b0, 1'b1, 2'b10, 1'b1);
        @(posedge clk); #1;
        addr_ph(8'h00, 1'b0, 1'b1, 2'b10, 1'b1);
        exp_q.push_back(32'h0);
        @(negedge clk); got = b16.HRDATA; e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL sync_too_early: got %h expected %h", got, e); end
        @(posedge clk); #1; idle16();
        exp_q.push_back(32'h0000_1234);
        @(negedge clk); got = b16.HRDATA; e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL sync_arrival: got %h expected %h", got, e); end
    endtask

    task automatic test_interrupt();
        logic [31:0] got, e;
        bus_write(8'h18, 32'h0000_FFFF);
        bus_write(8'h10, 32'h0000_0001);
        exp_q.push_back(32'h0);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL istat_cleared: got %h expected %h", got, e); end
        cyc(1);
        gpio16 = 16'h1235;
        cyc(2);
        tests_run++;
        if (int16 !== 1'b0) begin tests_failed++; $display("FAIL int_early: got %b expected 0", int16); end
        cyc(1);
        tests_run++;
        if (int16 !== 1'b1) begin tests_failed++; $display("FAIL int_rise: got %b expected 1", int16); end
        exp_q.push_back(32'h0000_0001);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL istat_rise: got %h expected %h", got, e); end
        bus_write(8'h18, 32'h0000_0001);
        cyc(1);
        tests_run++;
        if (int16 !== 1'b0) begin tests_failed++; $display("FAIL int_w1c: got %b expected 0", int16); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] got, e;
        bus_write(8'h14, 32'h0000_0001);
        cyc(3);
        gpio16 = 16'h1234;
        @(posedge clk); #1; addr_ph(8'h18, 1'b1, 1'b1, 2'b10, 1'b1);
        @(posedge clk); #1; idle16(); b16.HWDATA = 32'h0000_0001;
        tests_run++;
        if (int16 !== 1'b0) begin tests_failed++; $display("FAIL fall_early: got %b expected 0", int16); end
        @(posedge clk); #1;
        tests_run++;
        if (int16 !== 1'b1) begin tests_failed++; $display("FAIL set_beats_w1c_int: got %b expected 1", int16); end
        exp_q.push_back(32'h0000_0001);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL set_beats_w1c: got %h expected %h", got, e); end
    endtask

    task automatic test_dir_mask();
        logic [31:0] got, e;
        bus_write(8'h04, 32'h0000_0009);
        bus_write(8'h14, 32'h0);
        gpio16 = 16'h123C;
        cyc(5);
        exp_q.push_back(32'h0000_0001);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL output_no_edge: got %h expected %h", got, e); end
        bus_write(8'h18, 32'h0000_FFFF);
        exp_q.push_back(32'h0);
        bus_read(8'h18, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL final_clear: got %h expected %h", got, e); end
        tests_run++;
        if (int16 !== 1'b0) begin tests_failed++; $display("FAIL final_int: got %b expected 0", int16); end
    endtask

    task automatic test_reset_mid32();
        logic [31:0] got, e;
        w32(8'h04, 32'hFFFF_FFFF);
        w32(8'h00, 32'hA5A5_A5A5);
        cyc(1);
        tests_run++;
        if ({out32, en32} !== {32'hA5A5_A5A5, 32'hFFFF_FFFF}) begin
            tests_failed++;
            $display("FAIL w32_out: got out=%h en=%h expected a5a5a5a5/ffffffff", out32, en32);
        end
        exp_q.push_back(32'hA5A5_A5A5);
        r32(8'h00, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL w32_read: got %h expected %h", got, e); end
        w32(8'h00, 32'h0F0F_0F0F);
        #2 rst32_n = 1'b0;
        #1;
        tests_run++;
        if ({out32, en32, int32} !== {32'h0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL w32_reset: got out=%h en=%h int=%b expected 0/0/0", out32, en32, int32);
        end
        cyc(2);
        rst32_n = 1'b1;
        cyc(2);
        tests_run++;
        if ({out32, en32} !== {32'h0, 32'h0}) begin
            tests_failed++;
            $display("FAIL w32_abort: got out=%h en=%h expected 0/0", out32, en32);
        end
        exp_q.push_back(32'h0);
        r32(8'h04, got); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL w32_dir_after: got %h expected %h", got, e); end
    endtask

    initial begin
        rst_n = 1'b0; rst32_n = 1'b0;
        gpio16 = '0; gpio32 = '0;
        idle16(); b16.HADDR = '0; b16.HWDATA = '0;
        b32.HSEL = 1'b0; b32.HTRANS = 2'b00; b32.HWRITE = 1'b0; b32.HREADY = 1'b1;
        b32.HADDR = '0; b32.HWDATA = '0;
        test_reset();
        test_data_dir();
        test_set_clr();
        test_ignored();
        test_back_to_back();
        test_sync();
        test_interrupt();
        test_w1c_collision();
        test_dir_mask();
        test_reset_mid32();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
